motor_step_seq: RTL
===================

# motor_step_seq

Parametrised key-triggered stepper-motor sequencer: latches a play mode from LEFT_KEY, starts a timed run on any KEY press, and drives 4-wire coil phases at a fixed step period for a mode/key-dependent number of steps. It sits beside the launchpad key scanner and drives the board's step-motor pins. Compared with its fixed-function predecessor, it adds retrigger-on-press, a direction input, busy/done status, and a table-driven duration lookup.

## Interface
- STEP_PERIOD, 2000000: clocks per full step; must be ≥ 4 and even.
- NUM_KEYS, 9: number of play keys.
- DUR_W, 8: width of the duration field (in steps).
- CLK  in  1  system clock (24 MHz on board).
- RESET  in  1  synchronous, active-high reset.
- LEFT_KEY  in  4  mode-select keys, level, one clock high per press.
- Mode_Switch  in  1  enables mode 3.
- KEY  in  NUM_KEYS  play keys, level.
- DIR  in  1  0 = forward, 1 = reverse; sampled at each step boundary.
- MOTOR_OUT  out  4  coil phase pattern.
- BUSY  out  1  high while running.
- DONE  out  1  one-clock pulse when a run completes normally.
- ACTIVE_KEY  out  $clog2(NUM_KEYS)  index of the key driving the current or last run.

## Operation
- Reset values: MOTOR_OUT = 4'b1001, BUSY = 0, DONE = 0, ACTIVE_KEY = 0, mode = NONE, all counters = 0.
- Mode latch: the lowest set LEFT_KEY bit wins and sets mode 0–3. A mode change while BUSY aborts the run: go to IDLE with no DONE pulse, and MOTOR_OUT holds.
- Mode validity:
  - Modes 0 and 1 are always valid.
  - Mode 2 is never valid.
  - Mode 3 is valid only while Mode_Switch = 1. If Mode_Switch drops during a mode-3 run, the run aborts as above.
  - Mode NONE is invalid.
- Key select: the lowest-index set KEY bit wins. Key presses are ignored when the mode is invalid.
- FSM states are IDLE and RUN.
  - IDLE → RUN on any key press with a valid mode. Latch ACTIVE_KEY, load dur = DUR(mode, key), clear the period and step counters.
  - RUN + key press (any key, including the same one) → restart in RUN. Reload key and dur, clear the counters, keep the current phase. Retrigger takes priority over completion in the same clock.
  - RUN → IDLE when the period counter = STEP_PERIOD-1 and the step counter = dur-1. DONE pulses in that clock.
- Period counter: counts 0..STEP_PERIOD-1 in RUN and wraps. At each wrap the step counter increments and the phase advances by one according to DIR.
- Full-step sequence, forward: 1001 → 1010 → 0110 → 0101 → 1001. Reverse is the same list walked backwards.
- In IDLE, MOTOR_OUT holds the last phase; it does not return to 1001.
- Duration table, in steps (1 step = 1/12 s at defaults):
  - Mode 0, keys 0..8: 48, 24, 48, 24, 96, 24, 48, 24, 48.
  - Mode 1, keys 0..8: 18, 9, 18, 9, 9, 18, 18, 18, 18.
  - Mode 3: 24 for every key.
  - Keys at index ≥ 9 use 24 in every valid mode.
- Widths: the period counter is $clog2(STEP_PERIOD) bits and the step counter is DUR_W bits. Comparisons are unsigned and nothing saturates.

## Timing
- MOTOR_OUT, BUSY and DONE are registered.
- Key press at clock n → BUSY = 1 at n+1. The first phase change occurs STEP_PERIOD clocks after n+1.
- A run of dur steps keeps BUSY high for exactly dur × STEP_PERIOD clocks, with the last phase change coinciding with DONE.
- RESET mid-run: on the next clock all outputs take their reset values and the run is lost.
- A key held high across the run retriggers every clock, so the run never completes. This is intended: the key scanner delivers single-clock pulses.

## Configuration
- MOTOR_HALF_STEP_EN defined: phases advance at period-counter values STEP_PERIOD/2-1 and STEP_PERIOD-1, using the 8-entry forward sequence 1001, 1000, 1010, 0010, 0110, 0100, 0101, 0001 (reverse walks it backwards). Durations still count full periods, so run time is unchanged.
- Macro undefined: 4-entry full-step behaviour only, and no half-step logic is synthesised.

## Structure
- Package motor_pkg holds:
  - the mode enum (MODE_NONE, MODE_0..MODE_3);
  - the FSM state enum;
  - the full-step and half-step phase constant arrays;
  - the duration table constants.
- Sub-module motor_dur_lut: combinational (mode, key index) → dur, built from motor_pkg constants.

## Test plan
- STEP_PERIOD=8, mode 0 (LEFT_KEY=0001), KEY[1] pulse, DIR=0 → BUSY for 24×8 = 192 clocks, 24 phase changes 1001→1010→…, DONE pulse on the last, MOTOR_OUT holds 1001 afterwards.
- Mode 1, KEY[4] pulse, DIR=1 → 9 steps, phase order 1001→0101→0110→…, DONE after 72 clocks.
- Mode 3 with Mode_Switch=0, KEY[0] pulse → BUSY stays 0. With Mode_Switch=1 → 24-step run. Dropping Mode_Switch mid-run → BUSY=0 next clock, no DONE.
- Mode 0, KEY[4] run; at step 10 pulse KEY[3] → ACTIVE_KEY=3, run ends 24 steps after the retrigger, exactly one DONE.
- RESET asserted mid-run → next clock MOTOR_OUT=1001, BUSY=0, ACTIVE_KEY=0. A later KEY press with no mode selected is ignored.
- MOTOR_HALF_STEP_EN defined, STEP_PERIOD=8, mode 3, KEY[0] → 48 half-step phase changes every 4 clocks, forward 8-entry order, DONE at 192 clocks.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared types and constant tables for the key-triggered stepper sequencer.
package motor_pkg;

  typedef enum logic [2:0] {
    MODE_NONE,
    MODE_0,
    MODE_1,
    MODE_2,
    MODE_3
  } mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam int unsigned FULL_STEPS = 4;
  localparam int unsigned HALF_STEPS = 8;
  localparam int unsigned DUR_KEYS   = 9;

  // Coil patterns in forward order; reverse walks the same list backwards.
  localparam logic [3:0] FULL_STEP_SEQ [FULL_STEPS] = '{
    4'b1001, 4'b1010, 4'b0110, 4'b0101
  };
  localparam logic [3:0] HALF_STEP_SEQ [HALF_STEPS] = '{
    4'b1001, 4'b1000, 4'b1010, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0001
  };

  // Run lengths in full steps, indexed by key.
  localparam logic [7:0] DUR_MODE0 [DUR_KEYS] = '{
    8'd48, 8'd24, 8'd48, 8'd24, 8'd96, 8'd24, 8'd48, 8'd24, 8'd48
  };
  localparam logic [7:0] DUR_MODE1 [DUR_KEYS] = '{
    8'd18, 8'd9, 8'd18, 8'd9, 8'd9, 8'd18, 8'd18, 8'd18, 8'd18
  };
  localparam logic [7:0] DUR_DEFAULT = 8'd24;

  // Lowest set mode key wins.
  function automatic mode_t mode_decode(input logic [3:0] left_key);
    if (left_key[0])      return MODE_0;
    else if (left_key[1]) return MODE_1;
    else if (left_key[2]) return MODE_2;
    else if (left_key[3]) return MODE_3;
    else                  return MODE_NONE;
  endfunction

  // Mode 3 is only playable while the mode switch is on.
  function automatic logic mode_valid(input mode_t mode, input logic mode_switch);
    case (mode)
      MODE_0, MODE_1: return 1'b1;
      MODE_3:         return mode_switch;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/motor_dur_lut.sv
// Combinational run-length lookup: (mode, key index) -> duration in full steps.
module motor_dur_lut
  import motor_pkg::*;
#(
  parameter int unsigned KEY_W = 4,
  parameter int unsigned DUR_W = 8
) (
  input  mode_t            mode,
  input  logic [KEY_W-1:0] key,
  output logic [DUR_W-1:0] dur_c
);

  logic       in_table;
  logic [3:0] idx;

  // Keys beyond the table, and mode 3, use the default length.
  always_comb begin
    dur_c    = DUR_W'(DUR_DEFAULT);
    in_table = (32'(key) < DUR_KEYS);
    idx      = 4'(key);
    if (in_table) begin
      case (mode)
        MODE_0:  dur_c = DUR_W'(DUR_MODE0[idx]);
        MODE_1:  dur_c = DUR_W'(DUR_MODE1[idx]);
        default: dur_c = DUR_W'(DUR_DEFAULT);
      endcase
    end
  end

endmodule

// File: rtl/motor_step_seq.sv
// Key-triggered stepper sequencer with retrigger, direction and busy/done status.
// Define MOTOR_HALF_STEP_EN to drive the 8-entry half-step sequence.
module motor_step_seq
  import motor_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = 2000000,
  parameter int unsigned NUM_KEYS    = 9,
  parameter int unsigned DUR_W       = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [3:0]                  LEFT_KEY,
  input  logic                        Mode_Switch,
  input  logic [NUM_KEYS-1:0]         KEY,
  input  logic                        DIR,
  output logic [3:0]                  MOTOR_OUT,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [$clog2(NUM_KEYS)-1:0] ACTIVE_KEY
);

  localparam int unsigned KEY_W = $clog2(NUM_KEYS);
  localparam int unsigned PER_W = $clog2(STEP_PERIOD);
`ifdef MOTOR_HALF_STEP_EN
  localparam int unsigned PH_W  = 3;
`else
  localparam int unsigned PH_W  = 2;
`endif

  state_t             state, state_d;
  mode_t              mode, mode_d;
  logic [KEY_W-1:0]   key_d, sel_key;
  logic [DUR_W-1:0]   dur, dur_d, lut_dur;
  logic [PER_W-1:0]   period, period_d;
  logic [DUR_W-1:0]   step, step_d;
  logic [PH_W-1:0]    phase, phase_d;
  logic [3:0]         motor_d;
  logic               done_d;
  logic               key_press;
  logic               mode_change;
  logic               valid;

  motor_dur_lut #(
    .KEY_W (KEY_W),
    .DUR_W (DUR_W)
  ) u_dur_lut (
    .mode  (mode),
    .key   (sel_key),
    .dur_c (lut_dur)
  );

  // Lowest-index pressed key wins.
  always_comb begin
    key_press = |KEY;
    sel_key   = '0;
    for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
      if (KEY[i]) sel_key = KEY_W'(i);
    end
  end

  // Phase index to coil pattern.
  function automatic logic [3:0] phase_pattern(input logic [PH_W-1:0] idx);
`ifdef MOTOR_HALF_STEP_EN
    return HALF_STEP_SEQ[idx];
`else
    return FULL_STEP_SEQ[idx];
`endif
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    mode_d      = mode;
    key_d       = ACTIVE_KEY;
    dur_d       = dur;
    period_d    = period;
    step_d      = step;
    phase_d     = phase;
    motor_d     = MOTOR_OUT;
    done_d      = 1'b0;
    mode_change = 1'b0;
    valid       = mode_valid(mode, Mode_Switch);

    if (|LEFT_KEY) begin
      mode_d      = mode_decode(LEFT_KEY);
      mode_change = (mode_d != mode);
    end

    case (state)
      ST_IDLE: begin
        if (key_press && valid) begin
          state_d  = ST_RUN;
          key_d    = sel_key;
          dur_d    = lut_dur;
          period_d = '0;
          step_d   = '0;
        end
      end
      ST_RUN: begin
        if (mode_change || !valid) begin
          state_d = ST_IDLE;
        end else if (key_press) begin
          key_d    = sel_key;
          dur_d    = lut_dur;
          period_d = '0;
          step_d   = '0;
        end else if (period == PER_W'(STEP_PERIOD - 1)) begin
          period_d = '0;
          step_d   = step + DUR_W'(1);
          phase_d  = DIR ? phase - PH_W'(1) : phase + PH_W'(1);
          motor_d  = phase_pattern(phase_d);
          if (step == dur - DUR_W'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          period_d = period + PER_W'(1);
`ifdef MOTOR_HALF_STEP_EN
          if (period == PER_W'(STEP_PERIOD / 2 - 1)) begin
            phase_d = DIR ? phase - PH_W'(1) : phase + PH_W'(1);
            motor_d = phase_pattern(phase_d);
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      mode       <= MODE_NONE;
      ACTIVE_KEY <= '0;
      dur        <= '0;
      period     <= '0;
      step       <= '0;
      phase      <= '0;
      MOTOR_OUT  <= 4'b1001;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
    end else begin
      state      <= state_d;
      mode       <= mode_d;
      ACTIVE_KEY <= key_d;
      dur        <= dur_d;
      period     <= period_d;
      step       <= step_d;
      phase      <= phase_d;
      MOTOR_OUT  <= motor_d;
      BUSY       <= (state_d == ST_RUN);
      DONE       <= done_d;
    end
  end

endmodule
